// File: rtl/piso_stream_nbit.sv
// -----------------------------------------------------------------------------
// piso_stream_nbit
//   Parallel-in / serial-out shifter with a valid/ready load port, a stall input
//   and first/last framing flags. A word is serialised over exactly N shifting
//   cycles, MSB-first or LSB-first. A new word can be accepted on the edge that
//   retires the last bit, so consecutive frames run with no idle cycle.
//
// Handshake: a word on d_in is taken on a rising edge where ld_valid_in and
//   ld_ready_out are both 1. ld_ready_out never looks at ld_valid_in; it is 1
//   in IDLE, or on the last bit of a frame when that bit is being shifted out.
//   A source that sees ready low must keep valid and data stable.
//
// Ports:
//   clk           rising-edge clock
//   reset_al_in   asynchronous active-low reset
//   ld_valid_in   d_in holds a word to load
//   ld_ready_out  a word can be taken this cycle (combinational)
//   d_in[N-1:0]   parallel word
//   shift_en_in   1 = advance one bit this cycle, 0 = hold
//   q_out         serial bit (0 when idle)
//   q_valid_out   q_out carries a frame bit
//   first_out     q_out is the first bit of the frame
//   last_out      q_out is the last bit of the frame
//   busy_out      frame in progress (same as q_valid_out)
//
// The FSM state is held in state_q (type state_t) for hierarchical observation.
// -----------------------------------------------------------------------------
module piso_stream_nbit #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic         ld_valid_in,
  output logic         ld_ready_out,
  input  logic [N-1:0] d_in,
  input  logic         shift_en_in,
  output logic         q_out,
  output logic         q_valid_out,
  output logic         first_out,
  output logic         last_out,
  output logic         busy_out
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   sr_q, sr_d;

  logic           in_shift;
  logic           is_last;
  logic           head_bit;
  logic           load;

  assign in_shift = (state_q == SHIFT);
  assign is_last  = in_shift && (cnt_q == LAST_IDX);
  assign head_bit = MSB_FIRST ? sr_q[N-1] : sr_q[0];

  // Ready on the last bit only when that bit actually leaves this cycle;
  // a stalled last bit must stay on q_out, so no load is possible then.
  assign ld_ready_out = !in_shift || (is_last && shift_en_in);
  assign load         = ld_valid_in && ld_ready_out;

  // State register (shift register and counter travel with the state)
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    if (load) begin
      // Covers both a load from IDLE and the back-to-back load on the last bit.
      state_d = SHIFT;
      cnt_d   = '0;
      sr_d    = d_in;
    end else if (in_shift && shift_en_in) begin
      if (is_last) begin
        state_d = IDLE;
        cnt_d   = '0;
        sr_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (MSB_FIRST) begin
          sr_d = {sr_q[N-2:0], 1'b0};
        end else begin
          sr_d = {1'b0, sr_q[N-1:1]};
        end
      end
    end
  end

  // Output logic
  always_comb begin
    q_out       = 1'b0;
    q_valid_out = 1'b0;
    first_out   = 1'b0;
    last_out    = 1'b0;
    if (in_shift) begin
      q_out       = head_bit;
      q_valid_out = 1'b1;
      first_out   = (cnt_q == '0);
      last_out    = is_last;
    end
    busy_out = q_valid_out;
  end

endmodule
